// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional build macro SEQ_MULTIPLIER_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
`timescale 1ns/1ps

module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             cout
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [PW-1:0]      acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_nxt, done_nxt, cout_nxt;
  logic [WIDTH-1:0]   plo_nxt, phi_nxt;
  logic [PW-1:0]      acc_step_c;
  logic               early_exit_c;

  // Partial-product accumulate for the current multiplier LSB
  assign acc_step_c = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
  assign early_exit_c = (mplier == '0);
`else
  assign early_exit_c = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    plo_nxt    = product_lo;
    phi_nxt    = product_hi;
    cout_nxt   = cout;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          mcand_nxt  = PW'(a);
          mplier_nxt = b;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          busy_nxt   = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_nxt = 1'b1;
        if (early_exit_c) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          plo_nxt   = acc[WIDTH-1:0];
          phi_nxt   = acc[PW-1:WIDTH];
          cout_nxt  = |acc[PW-1:WIDTH];
        end else begin
          acc_nxt    = acc_step_c;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            plo_nxt   = acc_step_c[WIDTH-1:0];
            phi_nxt   = acc_step_c[PW-1:WIDTH];
            cout_nxt  = |acc_step_c[PW-1:WIDTH];
          end
        end
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_lo <= '0;
      product_hi <= '0;
      cout       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mcand      <= mcand_nxt;
      mplier     <= mplier_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      product_lo <= plo_nxt;
      product_hi <= phi_nxt;
      cout       <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random self-checking bench for seq_multiplier.
`timescale 1ns/1ps

module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] product_lo, product_hi;

  int checks   = 0;
  int failures = 0;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product_lo(product_lo),
    .product_hi(product_hi), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
    int m;
    if (bv == 16'h0) return 1;
    m = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) m = i;
    return (m + 2 > 16) ? 16 : m + 2;
`else
    return 16;
`endif
  endfunction

  // Called at the negedge after the accepting edge; n = edges until done seen
  task automatic wait_done(output int n, output int bn);
    n  = 0;
    bn = 0;
    while (1) begin
      if (busy === 1'b1) bn++;
      if (done === 1'b1 || n >= 40) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_mult(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp_p);
    int n, bn, lat;
    lat = exp_lat(y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    wait_done(n, bn);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(bn), 32'(lat + 1));
    check({tag, "_product"}, {product_hi, product_lo}, exp_p);
    check({tag, "_cout"}, 32'(cout), 32'(exp_p > 32'h0000_FFFF));
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, bn, dn;
    logic [15:0] rx, ry;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", {product_hi, product_lo}, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;

    run_mult("m3x5", 16'h0003, 16'h0005, 32'h0000_000F);
    run_mult("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // start held high with changing operands throughout RUN/DONE
    @(negedge clk);
    a = 16'h1234; b = 16'h0010; start = 1'b1;
    @(negedge clk);
    dn = 0; bn = 0;
    for (int k = 0; k < 17; k++) begin
      if (busy === 1'b1) bn++;
      if (done === 1'b1) begin
        dn++;
        check("hold_product", {product_hi, product_lo}, 32'h0001_2340);
      end
      a = 16'($urandom); b = 16'($urandom);
      if (k == 16) begin a = 16'h0002; b = 16'h0007; end
      if (done === 1'b1 || k == 16) break;
      @(negedge clk);
    end
    check("hold_done_count", 32'(dn), 32'd1);
    // DONE ignores start; the IDLE cycle that follows accepts it
    @(negedge clk);
    check("hold_idle_gap", 32'(busy), 32'd0);
    check("hold_no_done", 32'(done), 32'd0);
    @(negedge clk);
    check("hold_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n, bn);
    check("hold2_latency", 32'(n), 32'(exp_lat(16'h0007)));
    check("hold2_product", {product_hi, product_lo}, 32'h0000_000E);
    @(negedge clk);

    // Reset mid-operation
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", {product_hi, product_lo}, 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    run_mult("after_rst", 16'h0002, 16'h0003, 32'h0000_0006);

    // Reset and start together: start is lost
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 16'h0005; b = 16'h0005;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_start_busy1", 32'(busy), 32'd0);

    // Latency boundaries (early-exit build shortens these)
    run_mult("b0", 16'h1234, 16'h0000, 32'h0000_0000);
    run_mult("b1", 16'hABCD, 16'h0001, 32'h0000_ABCD);
    run_mult("b00ff", 16'h0101, 16'h00FF, 32'h0000_FFFF);
    run_mult("b4000", 16'h0004, 16'h4000, 32'h0001_0000);
    run_mult("b8000", 16'h0003, 16'h8000, 32'h0001_8000);

    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 4 == 1) ry = ry >> (i % 16);
      run_mult("rand", rx, ry, 32'(rx) * 32'(ry));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
